// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard control bundle: instruction fields and redirect in, pipeline control out.
// flush_state mirrors the flush FSM register so checkers can observe it.
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [6:0]        id_opcode;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              pc_change;
  logic              PC_Stall;
  logic              NOP_Ins;
  logic              flush;
  logic              busy;
  logic [CNT_W-1:0]  stall_cycles;
  logic              flush_state;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, pc_change,
    input  PC_Stall, NOP_Ins, flush, busy, stall_cycles, flush_state
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, pc_change,
    output PC_Stall, NOP_Ins, flush, busy, stall_cycles, flush_state
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard controller: per-register load countdown scoreboard, multi-cycle flush
// sequencing after a PC redirect, and a saturating load-use stall counter.
module hazard_scoreboard_unit #(
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                    clk,
  input logic                    rst,
  hazard_scoreboard_unit_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int SB_W     = $clog2(LOAD_LAT + 1);
  localparam int FC_W     = $clog2(FLUSH_CYCLES + 1);
  localparam logic [SB_W-1:0] SB_LOAD   = SB_W'(LOAD_LAT);
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [FC_W-1:0]   fcnt, fcnt_n;
  logic [SB_W-1:0]   sb [NUM_REGS];
  logic [CNT_W-1:0]  stall_cnt;
  logic              is_load;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              lu_stall;
  logic              flush_active;
  logic              load_issue;
  logic              any_pending;

  assign is_load  = (bus.id_opcode == 7'b0000011) || (bus.id_opcode == 7'b0000111);
  assign rs1_hit  = bus.id_rs1_used && (bus.id_rs1 != '0) && (sb[bus.id_rs1] != '0);
  assign rs2_hit  = bus.id_rs2_used && (bus.id_rs2 != '0) && (sb[bus.id_rs2] != '0);
  assign lu_stall = bus.id_valid && (rs1_hit || rs2_hit);

  assign flush_active = bus.pc_change || (state == FLUSH);
  // A load killed by the redirect, or one held back by its own hazard, must not be recorded.
  assign load_issue   = bus.id_valid && is_load && (bus.id_rd != '0) && !lu_stall && !flush_active;

  assign bus.flush        = flush_active;
  assign bus.NOP_Ins      = flush_active || lu_stall;
  assign bus.PC_Stall     = !flush_active && lu_stall;
  assign bus.busy         = any_pending || (state != IDLE);
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_state  = state;

  always_comb begin
    any_pending = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      any_pending = any_pending || (sb[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        sb[i] <= '0;
      end
    end else begin
      sb[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (load_issue && (bus.id_rd == REG_AW'(i))) begin
          sb[i] <= SB_LOAD;
        end else if (sb[i] != '0) begin
          sb[i] <= sb[i] - SB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  // A redirect always restarts the window, whether or not one is already running.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    if (bus.pc_change) begin
      if (FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        fcnt_n  = FC_RELOAD;
      end else begin
        state_n = IDLE;
        fcnt_n  = '0;
      end
    end else if (state == FLUSH) begin
      if (fcnt <= FC_W'(1)) begin
        state_n = IDLE;
        fcnt_n  = '0;
      end else begin
        fcnt_n  = fcnt - FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.PC_Stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances (short load latency / single-cycle flush,
// and long latency / three-cycle flush / 4-bit counter) driven with directed vectors.
module tb_hazard_scoreboard_unit;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_FLW  = 7'b0000111;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic clk;
  logic rst;

  hazard_scoreboard_unit_if #(.REG_AW(5), .CNT_W(16)) if_a ();
  hazard_scoreboard_unit_if #(.REG_AW(5), .CNT_W(4))  if_b ();

  hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_CYCLES(3), .CNT_W(4)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {dut_sel, PC_Stall, NOP_Ins, flush, busy, stall_cycles[15:0]}
  logic [20:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  // driver tasks
  task automatic idle_all();
    if_a.id_valid = 1'b0; if_a.id_opcode = 7'd0; if_a.id_rs1 = 5'd0; if_a.id_rs2 = 5'd0;
    if_a.id_rs1_used = 1'b0; if_a.id_rs2_used = 1'b0; if_a.id_rd = 5'd0; if_a.pc_change = 1'b0;
    if_b.id_valid = 1'b0; if_b.id_opcode = 7'd0; if_b.id_rs1 = 5'd0; if_b.id_rs2 = 5'd0;
    if_b.id_rs1_used = 1'b0; if_b.id_rs2_used = 1'b0; if_b.id_rd = 5'd0; if_b.pc_change = 1'b0;
  endtask

  task automatic expect_out(input bit sel, input logic e_stall, input logic e_nop,
                            input logic e_flush, input logic e_busy, input logic [15:0] e_cnt,
                            input string nm);
    exp_q.push_back({sel, e_stall, e_nop, e_flush, e_busy, e_cnt});
    name_q.push_back(nm);
  endtask

  // One cycle: drive the selected instance (the other idles), queue the expected outputs.
  task automatic step(input bit sel, input logic rst_v, input logic vld, input logic [6:0] op,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic pc,
                      input logic e_stall, input logic e_nop, input logic e_flush,
                      input logic e_busy, input logic [15:0] e_cnt, input string nm);
    idle_all();
    rst = rst_v;
    if (sel == 1'b0) begin
      if_a.id_valid = vld; if_a.id_opcode = op; if_a.id_rs1 = r1; if_a.id_rs1_used = u1;
      if_a.id_rs2 = r2; if_a.id_rs2_used = u2; if_a.id_rd = rd; if_a.pc_change = pc;
    end else begin
      if_b.id_valid = vld; if_b.id_opcode = op; if_b.id_rs1 = r1; if_b.id_rs1_used = u1;
      if_b.id_rs2 = r2; if_b.id_rs2_used = u2; if_b.id_rd = rd; if_b.pc_change = pc;
    end
    expect_out(sel, e_stall, e_nop, e_flush, e_busy, e_cnt, nm);
    @(posedge clk);
    #1;
  endtask

  // monitor: compares on the falling edge, away from the state-updating edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [20:0] e;
      logic [20:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e[20] == 1'b0)
        a = {1'b0, if_a.PC_Stall, if_a.NOP_Ins, if_a.flush, if_a.busy, if_a.stall_cycles};
      else
        a = {1'b1, if_b.PC_Stall, if_b.NOP_Ins, if_b.flush, if_b.busy, 12'd0, if_b.stall_cycles};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got stall=%b nop=%b flush=%b busy=%b cnt=%0d, expected stall=%b nop=%b flush=%b busy=%b cnt=%0d",
                 nm, a[19], a[18], a[17], a[16], a[15:0], e[19], e[18], e[17], e[16], e[15:0]);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ec;
    idle_all();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset state, both instances
    expect_out(1'b0, 0, 0, 0, 0, 16'd0, "reset_a");
    step(1'b1, 1'b1, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0,   0, 0, 0, 0, 16'd0, "reset_b");

    // T1 (A, LOAD_LAT=1): ld x5 ; add x6,x5,x1 -> exactly one bubble
    step(0, 0, 1, OP_LD,  5'd1, 1, 5'd0, 0, 5'd5, 0,   0, 0, 0, 0, 16'd0, "t1_load");
    step(0, 0, 1, OP_ADD, 5'd5, 1, 5'd1, 1, 5'd6, 0,   1, 1, 0, 1, 16'd0, "t1_use_stall");
    step(0, 0, 1, OP_ADD, 5'd5, 1, 5'd1, 1, 5'd6, 0,   0, 0, 0, 0, 16'd1, "t1_use_go");
    step(0, 0, 0, 7'd0,   5'd0, 0, 5'd0, 0, 5'd0, 0,   0, 0, 0, 0, 16'd1, "t1_idle");

    // T5 (A): redirect while a dependent load sits in ID -> flush wins, load not recorded
    step(0, 0, 1, OP_LD,  5'd1, 1, 5'd0, 0, 5'd5, 0,   0, 0, 0, 0, 16'd1, "t5_load_x5");
    step(0, 0, 1, OP_LD,  5'd5, 1, 5'd0, 0, 5'd8, 1,   0, 1, 1, 1, 16'd1, "t5_flush_wins");
    step(0, 0, 1, OP_ADD, 5'd8, 1, 5'd0, 0, 5'd9, 0,   0, 0, 0, 0, 16'd1, "t5_x8_not_rec");

    // T2 (B, LOAD_LAT=3): ld x7 ; nop ; use x7 -> 2 bubbles ; ld x0 ; use x0 -> none
    step(1, 0, 1, OP_LD,   5'd1, 1, 5'd0, 0, 5'd7, 0,  0, 0, 0, 0, 16'd0, "t2_load_x7");
    step(1, 0, 1, OP_ADDI, 5'd0, 1, 5'd0, 0, 5'd0, 0,  0, 0, 0, 1, 16'd0, "t2_nop");
    step(1, 0, 1, OP_ADD,  5'd7, 1, 5'd2, 1, 5'd3, 0,  1, 1, 0, 1, 16'd0, "t2_stall1");
    step(1, 0, 1, OP_ADD,  5'd7, 1, 5'd2, 1, 5'd3, 0,  1, 1, 0, 1, 16'd1, "t2_stall2");
    step(1, 0, 1, OP_ADD,  5'd7, 1, 5'd2, 1, 5'd3, 0,  0, 0, 0, 0, 16'd2, "t2_go");
    step(1, 0, 1, OP_LD,   5'd1, 1, 5'd0, 0, 5'd0, 0,  0, 0, 0, 0, 16'd2, "t2_load_x0");
    step(1, 0, 1, OP_ADD,  5'd0, 1, 5'd0, 1, 5'd4, 0,  0, 0, 0, 0, 16'd2, "t2_use_x0");

    // T3 (B): only sources actually read can stall; both source ports checked
    step(1, 0, 1, OP_LD,   5'd1, 1, 5'd0, 0, 5'd9, 0,  0, 0, 0, 0, 16'd2, "t3_load_x9");
    step(1, 0, 1, OP_ADD,  5'd2, 1, 5'd9, 0, 5'd4, 0,  0, 0, 0, 1, 16'd2, "t3_rs2_unused");
    step(1, 0, 1, OP_ADD,  5'd9, 1, 5'd2, 1, 5'd4, 0,  1, 1, 0, 1, 16'd2, "t3_rs1_stall");
    step(1, 0, 0, 7'd0,    5'd0, 0, 5'd0, 0, 5'd0, 0,  0, 0, 0, 1, 16'd3, "t3_idle1");
    step(1, 0, 0, 7'd0,    5'd0, 0, 5'd0, 0, 5'd0, 0,  0, 0, 0, 0, 16'd3, "t3_idle2");
    step(1, 0, 1, OP_FLW,  5'd1, 1, 5'd0, 0, 5'd10, 0, 0, 0, 0, 0, 16'd3, "t3_flw_x10");
    step(1, 0, 1, OP_ADD,  5'd0, 1, 5'd10, 1, 5'd4, 0, 1, 1, 0, 1, 16'd3, "t3_rs2_stall");
    step(1, 0, 0, 7'd0,    5'd0, 0, 5'd0, 0, 5'd0, 0,  0, 0, 0, 1, 16'd4, "t3_drain1");
    step(1, 0, 0, 7'd0,    5'd0, 0, 5'd0, 0, 5'd0, 0,  0, 0, 0, 1, 16'd4, "t3_drain2");
    step(1, 0, 0, 7'd0,    5'd0, 0, 5'd0, 0, 5'd0, 0,  0, 0, 0, 0, 16'd4, "t3_drained");

    // T4 (B, FLUSH_CYCLES=3): single pulse -> 3 cycles; re-pulse in 2nd cycle -> 4 cycles
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 1,     0, 1, 1, 0, 16'd4, "t4_f1");
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0,     0, 1, 1, 1, 16'd4, "t4_f2");
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0,     0, 1, 1, 1, 16'd4, "t4_f3");
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0,     0, 0, 0, 0, 16'd4, "t4_end");
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 1,     0, 1, 1, 0, 16'd4, "t4_r1");
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 1,     0, 1, 1, 1, 16'd4, "t4_r2_repulse");
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0,     0, 1, 1, 1, 16'd4, "t4_r3");
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0,     0, 1, 1, 1, 16'd4, "t4_r4");
    step(1, 0, 0, 7'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0,     0, 0, 0, 0, 16'd4, "t4_r_end");

    // T6 (B, CNT_W=4): 21 forced stalls from 4 -> saturates at 15 without wrapping
    ec = 4;
    for (int p = 0; p < 7; p++) begin
      step(1, 0, 1, OP_LD,  5'd1, 1, 5'd0, 0, 5'd3, 0, 0, 0, 0, 0, 16'(ec), "t6_load");
      for (int k = 0; k < 3; k++) begin
        step(1, 0, 1, OP_ADD, 5'd3, 1, 5'd0, 0, 5'd4, 0, 1, 1, 0, 1, 16'(ec), "t6_stall");
        ec = (ec < 15) ? ec + 1 : 15;
      end
    end
    step(1, 0, 1, OP_LD,  5'd1, 1, 5'd0, 0, 5'd3, 0,   0, 0, 0, 0, 16'd15, "t6_sat_load");
    step(1, 0, 1, OP_ADD, 5'd3, 1, 5'd0, 0, 5'd4, 0,   1, 1, 0, 1, 16'd15, "t6_sat_stall");
    step(1, 0, 1, OP_ADD, 5'd3, 1, 5'd0, 0, 5'd4, 1,   0, 1, 1, 1, 16'd15, "t6_flush_over_stall");
    step(1, 1, 1, OP_ADD, 5'd3, 1, 5'd0, 0, 5'd4, 0,   0, 0, 0, 0, 16'd0,  "t6_mid_reset");
    step(1, 0, 0, 7'd0,   5'd0, 0, 5'd0, 0, 5'd0, 0,   0, 0, 0, 0, 16'd0,  "t6_after_reset");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
